// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared opcode, ALU and mux encodings for the multi-cycle MIPS control sequencer,
// plus the decoded per-opcode select bundle passed from the decoder to the FSM.
package multicycle_ctrl_fsm_pkg;

    localparam int OPCODE_W_DEF   = 6;
    localparam int ALU_CTRL_W_DEF = 4;

    localparam logic [5:0] OP_ARITH = 6'd1;
    localparam logic [5:0] OP_ADDI  = 6'd2;
    localparam logic [5:0] OP_SUBI  = 6'd3;
    localparam logic [5:0] OP_LW    = 6'd4;
    localparam logic [5:0] OP_SW    = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_J     = 6'd7;
    localparam logic [5:0] OP_JAL   = 6'd8;
    localparam logic [5:0] OP_JR    = 6'd9;
    localparam logic [5:0] OP_JM    = 6'd10;
    localparam logic [5:0] OP_LDI   = 6'd11;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_FUNC = 4'd7;

    localparam logic [1:0] WA_RT    = 2'd0;
    localparam logic [1:0] WA_RD    = 2'd1;
    localparam logic [1:0] WA_R31   = 2'd2;
    localparam logic [1:0] WD_PC    = 2'd0;
    localparam logic [1:0] WD_MEM   = 2'd1;
    localparam logic [1:0] WD_ALU   = 2'd2;
    localparam logic [1:0] PCIN_SEQ = 2'd0;
    localparam logic [1:0] PCIN_JMP = 2'd1;
    localparam logic [1:0] PCIN_REG = 2'd2;

    // Which phase follows EXEC: write-back, memory access, or instruction ends in EXEC.
    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_WB      = 2'd1,
        CLS_MEM     = 2'd2,
        CLS_DONE    = 2'd3
    } op_class_e;

    typedef struct packed {
        op_class_e  cls;
        logic [3:0] alu_ctrl;
        logic       alu_in1_sel;
        logic       alu_in2_sel;
        logic       rd1_sel;
        logic [1:0] pc_in_sel;
        logic       is_branch;
        logic       is_jump;
        logic       is_link;
        logic       is_store;
        logic [1:0] wb_addr_sel;
        logic [1:0] wb_data_sel;
    } dec_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Combinational opcode decode: EXEC/WB select bundle and the phase class after EXEC.
module multicycle_ctrl_fsm_decode
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEF
) (
    input  logic [OPCODE_W-1:0] opcode,
    output dec_t                dec
);

    always_comb begin
        dec             = '0;
        dec.cls         = CLS_ILLEGAL;
        dec.alu_ctrl    = ALU_ADD;
        dec.wb_addr_sel = WA_RT;
        dec.wb_data_sel = WD_PC;
        dec.pc_in_sel   = PCIN_SEQ;
        case (opcode)
            OP_ARITH: begin
                dec.cls         = CLS_WB;
                dec.alu_ctrl    = ALU_FUNC;
                dec.wb_addr_sel = WA_RD;
                dec.wb_data_sel = WD_ALU;
            end
            OP_ADDI, OP_SUBI: begin
                dec.cls         = CLS_WB;
                dec.alu_ctrl    = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
                dec.alu_in2_sel = 1'b1;
                dec.wb_data_sel = WD_ALU;
            end
            OP_LDI: begin
                dec.cls         = CLS_WB;
                dec.alu_in1_sel = 1'b1;
                dec.alu_in2_sel = 1'b1;
                dec.wb_data_sel = WD_ALU;
            end
            OP_LW, OP_SW: begin
                dec.cls         = CLS_MEM;
                dec.alu_in2_sel = 1'b1;
                dec.is_store    = (opcode == OP_SW);
                dec.wb_data_sel = WD_MEM;
            end
            OP_BNE: begin
                dec.cls       = CLS_DONE;
                dec.alu_ctrl  = ALU_SUB;
                dec.is_branch = 1'b1;
            end
            OP_J, OP_JAL: begin
                dec.cls       = CLS_DONE;
                dec.pc_in_sel = PCIN_JMP;
                dec.is_jump   = 1'b1;
                // JAL links PC+1, which FETCH has already placed in PC.
                dec.is_link     = (opcode == OP_JAL);
                dec.wb_addr_sel = (opcode == OP_JAL) ? WA_R31 : WA_RT;
            end
            OP_JR, OP_JM: begin
                dec.cls       = CLS_DONE;
                dec.pc_in_sel = PCIN_REG;
                dec.is_jump   = 1'b1;
                dec.rd1_sel   = (opcode == OP_JM);
            end
            default: dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// single-port memory with a req/ready handshake.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int ALU_CTRL_W = ALU_CTRL_W_DEF,
    parameter int OPCODE_W   = OPCODE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_addr_sel,
    output logic                  ir_load,
    output logic                  pc_write,
    output logic                  reg_bank_read_addr_1_mux,
    output logic [1:0]            reg_bank_write_addr_mux,
    output logic [1:0]            reg_bank_write_data_mux,
    output logic                  ALU_input_1_mux,
    output logic                  ALU_input_2_mux,
    output logic [1:0]            PC_in_mux,
    output logic                  branch,
    output logic                  reg_bank_write_enable,
    output logic                  main_momory_write_enable,
    output logic [ALU_CTRL_W-1:0] ALU_controll,
    output logic                  instr_done,
    output logic                  illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_e;

    state_e              r_state;
    state_e              w_next;
    logic [OPCODE_W-1:0] r_opcode;
    logic [OPCODE_W-1:0] w_op;
    dec_t                w_dec;

    // The IR is only guaranteed from DECODE on, so the opcode is captured there
    // and later phases decode the captured copy.
    assign w_op = (r_state == S_DECODE) ? opcode : r_opcode;

    multicycle_ctrl_fsm_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode (w_op),
        .dec    (w_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_opcode <= opcode;
        end
    end

    always_comb begin
        w_next                   = r_state;
        mem_req                  = 1'b0;
        mem_addr_sel             = 1'b0;
        ir_load                  = 1'b0;
        pc_write                 = 1'b0;
        reg_bank_read_addr_1_mux = 1'b0;
        reg_bank_write_addr_mux  = WA_RT;
        reg_bank_write_data_mux  = WD_PC;
        ALU_input_1_mux          = 1'b0;
        ALU_input_2_mux          = 1'b0;
        PC_in_mux                = PCIN_SEQ;
        branch                   = 1'b0;
        reg_bank_write_enable    = 1'b0;
        main_momory_write_enable = 1'b0;
        ALU_controll             = '0;
        instr_done               = 1'b0;
        illegal_op               = 1'b0;

        // ALU operand selects stay stable from EXEC through MEM and WB.
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            ALU_controll             = ALU_CTRL_W'(w_dec.alu_ctrl);
            ALU_input_1_mux          = w_dec.alu_in1_sel;
            ALU_input_2_mux          = w_dec.alu_in2_sel;
            reg_bank_read_addr_1_mux = w_dec.rd1_sel;
        end

        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec.cls == CLS_ILLEGAL) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_dec.cls)
                    CLS_WB:  w_next = S_WB;
                    CLS_MEM: w_next = S_MEM;
                    CLS_DONE: begin
                        branch                  = w_dec.is_branch;
                        PC_in_mux               = w_dec.pc_in_sel;
                        pc_write                = w_dec.is_branch ? ~alu_zero : w_dec.is_jump;
                        reg_bank_write_enable   = w_dec.is_link;
                        reg_bank_write_addr_mux = w_dec.wb_addr_sel;
                        reg_bank_write_data_mux = WD_PC;
                        instr_done              = 1'b1;
                        w_next                  = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    if (w_dec.is_store) begin
                        main_momory_write_enable = 1'b1;
                        instr_done               = 1'b1;
                        w_next                   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_bank_write_enable   = 1'b1;
                reg_bank_write_addr_mux = w_dec.wb_addr_sel;
                reg_bank_write_data_mux = w_dec.wb_data_sel;
                instr_done              = 1'b1;
                w_next                  = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for the multi-cycle control sequencer.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_addr_sel, ir_load, pc_write, rd1_mux;
    logic [1:0] wa_mux, wd_mux, pc_in_mux;
    logic       in1_mux, in2_mux, branch, reg_we, mem_we;
    logic [3:0] alu_ctrl;
    logic       instr_done, illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.ALU_CTRL_W(4), .OPCODE_W(6)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .opcode                   (opcode),
        .alu_zero                 (alu_zero),
        .mem_ready                (mem_ready),
        .mem_req                  (mem_req),
        .mem_addr_sel             (mem_addr_sel),
        .ir_load                  (ir_load),
        .pc_write                 (pc_write),
        .reg_bank_read_addr_1_mux (rd1_mux),
        .reg_bank_write_addr_mux  (wa_mux),
        .reg_bank_write_data_mux  (wd_mux),
        .ALU_input_1_mux          (in1_mux),
        .ALU_input_2_mux          (in2_mux),
        .PC_in_mux                (pc_in_mux),
        .branch                   (branch),
        .reg_bank_write_enable    (reg_we),
        .main_momory_write_enable (mem_we),
        .ALU_controll             (alu_ctrl),
        .instr_done               (instr_done),
        .illegal_op               (illegal_op)
    );

    logic [21:0] act;
    assign act = {mem_req, mem_addr_sel, ir_load, pc_write, rd1_mux, wa_mux, wd_mux,
                  in1_mux, in2_mux, pc_in_mux, branch, reg_we, mem_we, alu_ctrl,
                  instr_done, illegal_op};

    function automatic logic [21:0] pk(
        input logic mreq, masel, irl, pcw, rd1,
        input logic [1:0] wa, wd,
        input logic in1, in2,
        input logic [1:0] pcin,
        input logic br, we, mwe,
        input logic [3:0] alu,
        input logic done, ill);
        return {mreq, masel, irl, pcw, rd1, wa, wd, in1, in2, pcin, br, we, mwe, alu, done, ill};
    endfunction

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic r, input logic [5:0] op,
                                input logic rdy, input logic z, input logic [21:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = op; v.rdy = rdy; v.z = z; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    logic [21:0] Z, FS, FR, LWM, SWE;

    initial begin
        rst = 1'b1; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b0;

        Z   = '0;
        FS  = pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        FR  = pk(1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
        LWM = pk(1,1,0,0,0,0,0,0,1,0,0,0,0,0,0,0);
        SWE = pk(0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0);

        for (int i = 0; i < 3; i++) add("reset", 1, 6'd1, 1, 0, Z);
        add("idle",      0, 6'd1, 1, 0, Z);
        add("ar_fetch",  0, 6'd1, 1, 0, FR);
        add("ar_decode", 0, 6'd1, 1, 0, Z);
        add("ar_exec",   0, 6'd1, 1, 0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,7,0,0));
        add("ar_wb",     0, 6'd1, 1, 0, pk(0,0,0,0,0,1,2,0,0,0,0,1,0,7,1,0));
        add("lw_fwait",  0, 6'd4, 0, 0, FS);
        add("lw_fwait",  0, 6'd4, 0, 0, FS);
        add("lw_fetch",  0, 6'd4, 1, 0, FR);
        add("lw_decode", 0, 6'd4, 1, 0, Z);
        add("lw_exec",   0, 6'd63, 1, 0, SWE);
        for (int i = 0; i < 3; i++) add("lw_mwait", 0, 6'd63, 0, 0, LWM);
        add("lw_mem",    0, 6'd63, 1, 0, LWM);
        add("lw_wb",     0, 6'd63, 1, 0, pk(0,0,0,0,0,0,1,0,1,0,0,1,0,0,1,0));
        add("bne0_fetch",  0, 6'd6, 1, 0, FR);
        add("bne0_decode", 0, 6'd6, 1, 0, Z);
        add("bne0_exec",   0, 6'd6, 1, 0, pk(0,0,0,1,0,0,0,0,0,0,1,0,0,1,1,0));
        add("bne1_fetch",  0, 6'd6, 1, 1, FR);
        add("bne1_decode", 0, 6'd6, 1, 1, Z);
        add("bne1_exec",   0, 6'd6, 1, 1, pk(0,0,0,0,0,0,0,0,0,0,1,0,0,1,1,0));
        add("jal_fetch",   0, 6'd8, 1, 0, FR);
        add("jal_decode",  0, 6'd8, 1, 0, Z);
        add("jal_exec",    0, 6'd8, 1, 0, pk(0,0,0,1,0,2,0,0,0,1,0,1,0,0,1,0));
        add("sw_fetch",    0, 6'd5, 1, 0, FR);
        add("sw_decode",   0, 6'd5, 1, 0, Z);
        add("sw_exec",     0, 6'd5, 1, 0, SWE);
        add("sw_mwait",    0, 6'd5, 0, 0, LWM);
        add("sw_mem",      0, 6'd5, 1, 0, pk(1,1,0,0,0,0,0,0,1,0,0,0,1,0,1,0));
        add("ldi_fetch",   0, 6'd11, 1, 0, FR);
        add("ldi_decode",  0, 6'd11, 1, 0, Z);
        add("ldi_exec",    0, 6'd11, 1, 0, pk(0,0,0,0,0,0,0,1,1,0,0,0,0,0,0,0));
        add("ldi_wb",      0, 6'd11, 1, 0, pk(0,0,0,0,0,0,2,1,1,0,0,1,0,0,1,0));
        add("jm_fetch",    0, 6'd10, 1, 0, FR);
        add("jm_decode",   0, 6'd10, 1, 0, Z);
        add("jm_exec",     0, 6'd10, 1, 0, pk(0,0,0,1,1,0,0,0,0,2,0,0,0,0,1,0));
        add("ill0_fetch",  0, 6'd0, 1, 0, FR);
        add("ill0_decode", 0, 6'd0, 1, 0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1));
        add("ill63_fetch", 0, 6'd63, 1, 0, FR);
        add("ill63_decode",0, 6'd63, 1, 0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1));
        add("rm_fetch",    0, 6'd4, 1, 0, FR);
        add("rm_decode",   0, 6'd4, 1, 0, Z);
        add("rm_exec",     0, 6'd4, 1, 0, SWE);
        add("rm_mwait",    0, 6'd4, 0, 0, LWM);
        add("rm_reset",    1, 6'd4, 1, 0, Z);
        add("rm_idle",     0, 6'd4, 1, 0, Z);
        add("rm_fwait",    0, 6'd4, 0, 0, FS);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; opcode = vecs[i].op;
            mem_ready = vecs[i].rdy; alu_zero = vecs[i].z;
            #1;
            check(vecs[i].name, {10'd0, act}, {10'd0, vecs[i].exp});
        end

        // Extended fetch stall: request held, no strobes while not ready.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check("stall_hold", {29'd0, mem_req, ir_load, pc_write}, {29'd0, 3'b100});
        end

        // JR with zero-wait memory finishes in three cycles from the fetch hit.
        begin
            int  n;
            bit  got;
            n = 0; got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                opcode = 6'd9; mem_ready = 1'b1;
                #1;
                n++;
                if (instr_done) begin
                    got = 1'b1;
                    check("jr_exec", {28'd0, pc_in_mux, pc_write, branch}, {28'd0, 2'd2, 1'b1, 1'b0});
                end
            end
            check("jr_latency", {31'd0, got}, 32'd1);
            check("jr_cycles", n, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
